// File: rtl/alu_rs.sv
// Reservation station feeding the ALU: holds ops until both operands are ready, wakes
// them from the two result buses, issues one per cycle, and squashes or updates on branch resolution.
module alu_rs #(
   parameter int ENTRIES = 8,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4,
   parameter int OP_W    = 5,
   parameter int ADDR_W  = 32,
   parameter int BTAG_W  = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              dispEn,
   input  logic [OP_W-1:0]   dispOpCode,
   input  logic              dispRdyO,
   input  logic              dispRdyT,
   input  logic [DATA_W-1:0] dispOperandO,
   input  logic [DATA_W-1:0] dispOperandT,
   input  logic [TAG_W-1:0]  dispTagO,
   input  logic [TAG_W-1:0]  dispTagT,
   input  logic [TAG_W-1:0]  dispWrtTag,
   input  logic [ADDR_W-1:0] dispAddr,
   input  logic [BTAG_W-1:0] dispBranchTag,
   output logic              rsFull,
   input  logic              cdbAEn,
   input  logic [TAG_W-1:0]  cdbATag,
   input  logic [DATA_W-1:0] cdbAData,
   input  logic              cdbBEn,
   input  logic [TAG_W-1:0]  cdbBTag,
   input  logic [DATA_W-1:0] cdbBData,
   input  logic              misTaken,
   input  logic              bFreeEn,
   input  logic [1:0]        bFreeNum,
   output logic              ALUworkEn,
   output logic [DATA_W-1:0] operandO,
   output logic [DATA_W-1:0] operandT,
   output logic [TAG_W-1:0]  wrtTag,
   output logic [OP_W-1:0]   opCode,
   output logic [ADDR_W-1:0] instAddr,
   output logic [BTAG_W-1:0] instBranchTag
);

   localparam int IDX_W = $clog2(ENTRIES);

   typedef struct packed {
      logic              valid;
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] vo;
      logic              rdyo;
      logic [TAG_W-1:0]  qo;
      logic [DATA_W-1:0] vt;
      logic              rdyt;
      logic [TAG_W-1:0]  qt;
      logic [TAG_W-1:0]  wtag;
      logic [ADDR_W-1:0] addr;
      logic [BTAG_W-1:0] btag;
   } ent_t;

   ent_t ent_q [ENTRIES];
   ent_t ent_d [ENTRIES];
   ent_t new_ent;
   ent_t iss_ent;

   logic [ENTRIES-1:0] valid_vec;
   logic [ENTRIES-1:0] ready_vec;
   logic [IDX_W-1:0]   iss_idx;
   logic [IDX_W-1:0]   free_idx;
   logic               iss_any;
   logic               iss_live;
   logic               full;
   logic               disp_ok;
   logic               bfree_ok;

   logic              work_d;
   logic [DATA_W-1:0] opo_d;
   logic [DATA_W-1:0] opt_d;
   logic [TAG_W-1:0]  wtag_d;
   logic [OP_W-1:0]   op_d;
   logic [ADDR_W-1:0] addr_d;
   logic [BTAG_W-1:0] btag_d;

   always_comb begin
      valid_vec = '0;
      ready_vec = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         valid_vec[i] = ent_q[i].valid;
         ready_vec[i] = ent_q[i].valid & ent_q[i].rdyo & ent_q[i].rdyt;
      end
   end

   // descending scan so the lowest index wins both searches
   always_comb begin
      iss_any  = 1'b0;
      iss_idx  = '0;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (ready_vec[i]) begin
            iss_any = 1'b1;
            iss_idx = IDX_W'(i);
         end
         if (!valid_vec[i]) free_idx = IDX_W'(i);
      end
   end

   assign full     = &valid_vec;
   assign rsFull   = full;
   assign bfree_ok = bFreeEn & ~misTaken;
   assign disp_ok  = dispEn & ~full & ~(misTaken & dispBranchTag[bFreeNum]);

   always_comb begin
      new_ent       = '0;
      new_ent.valid = 1'b1;
      new_ent.op    = dispOpCode;
      new_ent.qo    = dispTagO;
      new_ent.qt    = dispTagT;
      new_ent.wtag  = dispWrtTag;
      new_ent.addr  = dispAddr;
      new_ent.btag  = dispBranchTag;
      new_ent.rdyo  = 1'b1;
      new_ent.rdyt  = 1'b1;
      if (dispRdyO)                           new_ent.vo = dispOperandO;
      else if (cdbAEn && dispTagO == cdbATag) new_ent.vo = cdbAData;
      else if (cdbBEn && dispTagO == cdbBTag) new_ent.vo = cdbBData;
      else                                    new_ent.rdyo = 1'b0;
      if (dispRdyT)                           new_ent.vt = dispOperandT;
      else if (cdbAEn && dispTagT == cdbATag) new_ent.vt = cdbAData;
      else if (cdbBEn && dispTagT == cdbBTag) new_ent.vt = cdbBData;
      else                                    new_ent.rdyt = 1'b0;
      if (bfree_ok) new_ent.btag[bFreeNum] = 1'b0;
   end

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].valid) begin
            if (!ent_q[i].rdyo) begin
               if (cdbAEn && ent_q[i].qo == cdbATag) begin
                  ent_d[i].vo   = cdbAData;
                  ent_d[i].rdyo = 1'b1;
               end else if (cdbBEn && ent_q[i].qo == cdbBTag) begin
                  ent_d[i].vo   = cdbBData;
                  ent_d[i].rdyo = 1'b1;
               end
            end
            if (!ent_q[i].rdyt) begin
               if (cdbAEn && ent_q[i].qt == cdbATag) begin
                  ent_d[i].vt   = cdbAData;
                  ent_d[i].rdyt = 1'b1;
               end else if (cdbBEn && ent_q[i].qt == cdbBTag) begin
                  ent_d[i].vt   = cdbBData;
                  ent_d[i].rdyt = 1'b1;
               end
            end
            if (misTaken && ent_q[i].btag[bFreeNum]) ent_d[i].valid = 1'b0;
            else if (bfree_ok)                      ent_d[i].btag[bFreeNum] = 1'b0;
         end
      end
      if (iss_any) ent_d[iss_idx].valid = 1'b0;
      if (disp_ok) ent_d[free_idx] = new_ent;
   end

   // a squashed pick still frees its slot but never reaches the output regs
   always_comb begin
      iss_ent  = ent_q[iss_idx];
      iss_live = iss_any & ~(misTaken & iss_ent.btag[bFreeNum]);
      work_d   = iss_live;
      opo_d    = operandO;
      opt_d    = operandT;
      wtag_d   = wrtTag;
      op_d     = opCode;
      addr_d   = instAddr;
      btag_d   = instBranchTag;
      if (iss_live) begin
         opo_d  = iss_ent.vo;
         opt_d  = iss_ent.vt;
         wtag_d = iss_ent.wtag;
         op_d   = iss_ent.op;
         addr_d = iss_ent.addr;
         btag_d = iss_ent.btag;
      end
      if (bfree_ok) btag_d[bFreeNum] = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
         ALUworkEn     <= 1'b0;
         operandO      <= '0;
         operandT      <= '0;
         wrtTag        <= '0;
         opCode        <= '0;
         instAddr      <= '0;
         instBranchTag <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
         ALUworkEn     <= work_d;
         operandO      <= opo_d;
         operandT      <= opt_d;
         wrtTag        <= wtag_d;
         opCode        <= op_d;
         instAddr      <= addr_d;
         instBranchTag <= btag_d;
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a slot-array reference model queues the expected output
// state for every clocked cycle; an independent monitor pops and compares after each edge.
module tb_alu_rs;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        dispEn = 1'b0;
   logic [4:0]  dispOpCode = '0;
   logic        dispRdyO = 1'b0, dispRdyT = 1'b0;
   logic [31:0] dispOperandO = '0, dispOperandT = '0;
   logic [3:0]  dispTagO = '0, dispTagT = '0, dispWrtTag = '0;
   logic [31:0] dispAddr = '0;
   logic [3:0]  dispBranchTag = '0;
   logic        rsFull;
   logic        cdbAEn = 1'b0, cdbBEn = 1'b0;
   logic [3:0]  cdbATag = '0, cdbBTag = '0;
   logic [31:0] cdbAData = '0, cdbBData = '0;
   logic        misTaken = 1'b0, bFreeEn = 1'b0;
   logic [1:0]  bFreeNum = '0;
   logic        ALUworkEn;
   logic [31:0] operandO, operandT;
   logic [3:0]  wrtTag;
   logic [4:0]  opCode;
   logic [31:0] instAddr;
   logic [3:0]  instBranchTag;

   alu_rs dut (
      .clk(clk), .rstn(rstn), .dispEn(dispEn), .dispOpCode(dispOpCode),
      .dispRdyO(dispRdyO), .dispRdyT(dispRdyT), .dispOperandO(dispOperandO),
      .dispOperandT(dispOperandT), .dispTagO(dispTagO), .dispTagT(dispTagT),
      .dispWrtTag(dispWrtTag), .dispAddr(dispAddr), .dispBranchTag(dispBranchTag),
      .rsFull(rsFull), .cdbAEn(cdbAEn), .cdbATag(cdbATag), .cdbAData(cdbAData),
      .cdbBEn(cdbBEn), .cdbBTag(cdbBTag), .cdbBData(cdbBData), .misTaken(misTaken),
      .bFreeEn(bFreeEn), .bFreeNum(bFreeNum), .ALUworkEn(ALUworkEn),
      .operandO(operandO), .operandT(operandT), .wrtTag(wrtTag), .opCode(opCode),
      .instAddr(instAddr), .instBranchTag(instBranchTag)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        valid;
      bit [4:0]  op;
      bit [31:0] vo, vt;
      bit        ro, rt;
      bit [3:0]  qo, qt, wtag, btag;
      bit [31:0] addr;
   } ment_t;

   typedef struct {
      bit        work;
      bit        full;
      bit [31:0] opo, opt, addr;
      bit [3:0]  wtag, btag;
      bit [4:0]  op;
   } exp_t;

   ment_t m [N];
   exp_t  hold;
   exp_t  exp_q [$];
   int    checks = 0;
   int    failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m[i] = '{default: 0};
      hold = '{default: 0};
   endfunction

   function automatic int model_count();
      int c = 0;
      foreach (m[i]) if (m[i].valid) c++;
      return c;
   endfunction

   // resolve a not-ready operand against the buses; A has priority over B
   function automatic void resolve(input bit [3:0] q, inout bit r, inout bit [31:0] v);
      if (r) return;
      if (cdbAEn && q == cdbATag) begin v = cdbAData; r = 1; end
      else if (cdbBEn && q == cdbBTag) begin v = cdbBData; r = 1; end
   endfunction

   // predicts the outcome of the coming edge from current inputs and pushes it
   function automatic void model_step();
      ment_t old [N];
      int    pick = -1;
      int    slot = -1;
      bit    was_full;
      int    b = int'(bFreeNum);
      old = m;
      was_full = (model_count() == N);
      for (int i = 0; i < N; i++) begin
         if (pick < 0 && old[i].valid && old[i].ro && old[i].rt) pick = i;
         if (slot < 0 && !old[i].valid) slot = i;
      end
      hold.work = 0;
      if (pick >= 0 && !(misTaken && old[pick].btag[b])) begin
         hold.work = 1;
         hold.opo  = old[pick].vo;
         hold.opt  = old[pick].vt;
         hold.wtag = old[pick].wtag;
         hold.op   = old[pick].op;
         hold.addr = old[pick].addr;
         hold.btag = old[pick].btag;
      end
      if (bFreeEn && !misTaken) hold.btag[b] = 0;
      for (int i = 0; i < N; i++) begin
         if (!m[i].valid) continue;
         resolve(m[i].qo, m[i].ro, m[i].vo);
         resolve(m[i].qt, m[i].rt, m[i].vt);
         if (misTaken && m[i].btag[b]) m[i].valid = 0;
         else if (bFreeEn) m[i].btag[b] = 0;
      end
      if (pick >= 0) m[pick].valid = 0;
      if (dispEn && !was_full && !(misTaken && dispBranchTag[b])) begin
         ment_t e;
         e.valid = 1;
         e.op = dispOpCode; e.qo = dispTagO; e.qt = dispTagT;
         e.wtag = dispWrtTag; e.addr = dispAddr; e.btag = dispBranchTag;
         e.ro = dispRdyO; e.vo = dispRdyO ? dispOperandO : 32'h0;
         e.rt = dispRdyT; e.vt = dispRdyT ? dispOperandT : 32'h0;
         resolve(e.qo, e.ro, e.vo);
         resolve(e.qt, e.rt, e.vt);
         if (bFreeEn && !misTaken) e.btag[b] = 0;
         m[slot] = e;
      end
      hold.full = (model_count() == N);
      exp_q.push_back(hold);
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ALUworkEn", 64'(ALUworkEn), 64'(e.work));
            chk("rsFull", 64'(rsFull), 64'(e.full));
            chk("operandO", 64'(operandO), 64'(e.opo));
            chk("operandT", 64'(operandT), 64'(e.opt));
            chk("wrtTag", 64'(wrtTag), 64'(e.wtag));
            chk("opCode", 64'(opCode), 64'(e.op));
            chk("instAddr", 64'(instAddr), 64'(e.addr));
            chk("instBranchTag", 64'(instBranchTag), 64'(e.btag));
         end
      end
   end

   task automatic idle();
      dispEn = 0; dispRdyO = 0; dispRdyT = 0; dispBranchTag = '0;
      cdbAEn = 0; cdbBEn = 0; misTaken = 0; bFreeEn = 0; bFreeNum = '0;
   endtask

   // inputs set by the caller are applied at the falling edge; returns at rise + 2
   task automatic cyc();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #2;
      idle();
   endtask

   task automatic disp(input bit [4:0] op, input bit ro, input bit [31:0] vo, input bit [3:0] qo,
                       input bit rt, input bit [31:0] vt, input bit [3:0] qt,
                       input bit [3:0] wt, input bit [3:0] bt);
      dispEn = 1; dispOpCode = op; dispRdyO = ro; dispOperandO = vo; dispTagO = qo;
      dispRdyT = rt; dispOperandT = vt; dispTagT = qt; dispWrtTag = wt;
      dispAddr = {24'h1000_00, 3'b0, op}; dispBranchTag = bt;
   endtask

   task automatic wake_a(input bit [3:0] t, input bit [31:0] d);
      cdbAEn = 1; cdbATag = t; cdbAData = d;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         wake_a(4'(i % 16), 32'hD000 + 32'(i));
         cdbBEn = 1; cdbBTag = 4'((i + 8) % 16); cdbBData = 32'hE000 + 32'(i);
         cyc();
      end
   endtask

   initial begin : driver
      model_reset();
      #3;
      chk("reset_work", 64'(ALUworkEn), 64'd0);
      chk("reset_full", 64'(rsFull), 64'd0);
      chk("reset_opO", 64'(operandO), 64'd0);
      @(posedge clk); #2; @(posedge clk); #2;
      rstn = 1;

      // both-ready dispatch issues one edge later
      disp(5'd1, 1, 32'd3, 4'd0, 1, 32'd4, 4'd0, 4'd1, 4'd0);
      cyc();
      chk("add_lat0", 64'(ALUworkEn), 64'd0);
      cyc();
      chk("add_work", 64'(ALUworkEn), 64'd1);
      chk("add_opO", 64'(operandO), 64'd3);
      chk("add_opT", 64'(operandT), 64'd4);

      // wakeup from bus A
      disp(5'd2, 0, 32'd0, 4'd5, 1, 32'd7, 4'd0, 4'd2, 4'd0);
      cyc();
      wake_a(4'd5, 32'h55);
      cyc();
      chk("wake_notyet", 64'(ALUworkEn), 64'd0);
      cyc();
      chk("wake_work", 64'(ALUworkEn), 64'd1);
      chk("wake_opO", 64'(operandO), 64'h55);

      // fill the station, drop a dispatch while full, then free one slot
      for (int i = 0; i < N; i++) begin
         disp(5'(8 + i), 0, 32'd0, 4'(i), 1, 32'd9, 4'd0, 4'(i), 4'd0);
         cyc();
      end
      chk("fill_full", 64'(rsFull), 64'd1);
      disp(5'd31, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0, 4'd15, 4'd0);
      cyc();
      chk("drop_full", 64'(rsFull), 64'd1);
      chk("drop_noissue", 64'(ALUworkEn), 64'd0);
      wake_a(4'd2, 32'hAB);
      cyc();
      cyc();
      chk("fill_issue", 64'(ALUworkEn), 64'd1);
      chk("fill_opO", 64'(operandO), 64'hAB);
      chk("fill_op", 64'(opCode), 64'd10);
      chk("fill_notfull", 64'(rsFull), 64'd0);
      drain(20);

      // mispredict on bit 1 squashes only the 0010 entry
      disp(5'd3, 0, 32'd0, 4'd10, 1, 32'd1, 4'd0, 4'd3, 4'b0010);
      cyc();
      disp(5'd4, 0, 32'd0, 4'd11, 1, 32'd2, 4'd0, 4'd4, 4'b0001);
      cyc();
      misTaken = 1; bFreeNum = 2'd1;
      cyc();
      wake_a(4'd10, 32'h10);
      cdbBEn = 1; cdbBTag = 4'd11; cdbBData = 32'h11;
      cyc();
      cyc();
      chk("mis_work", 64'(ALUworkEn), 64'd1);
      chk("mis_btag", 64'(instBranchTag), 64'b0001);
      chk("mis_op", 64'(opCode), 64'd4);
      cyc();
      chk("mis_gone", 64'(ALUworkEn), 64'd0);

      // branch freed correct on bit 0
      disp(5'd5, 0, 32'd0, 4'd12, 1, 32'd3, 4'd0, 4'd5, 4'b0011);
      cyc();
      bFreeEn = 1; bFreeNum = 2'd0;
      cyc();
      wake_a(4'd12, 32'h12);
      cyc();
      cyc();
      chk("bfree_work", 64'(ALUworkEn), 64'd1);
      chk("bfree_btag", 64'(instBranchTag), 64'b0010);

      // asynchronous reset with five waiting entries
      for (int i = 0; i < 5; i++) begin
         disp(5'(16 + i), 0, 32'd0, 4'(i), 0, 32'd0, 4'(i + 8), 4'(i), 4'd0);
         cyc();
      end
      #2;
      rstn = 0;
      #1;
      model_reset();
      chk("mid_reset_work", 64'(ALUworkEn), 64'd0);
      chk("mid_reset_full", 64'(rsFull), 64'd0);
      @(posedge clk); #2;
      rstn = 1;
      drain(4);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 3) != 0) begin
            disp(5'($urandom), 1'($urandom), $urandom, 4'($urandom_range(0, 7)),
                 1'($urandom), $urandom, 4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
            dispAddr = $urandom;
         end
         if ($urandom_range(0, 2) == 0) wake_a(4'($urandom_range(0, 7)), $urandom);
         if ($urandom_range(0, 2) == 0) begin
            cdbBEn = 1; cdbBTag = 4'($urandom_range(0, 7)); cdbBData = $urandom;
         end
         if ($urandom_range(0, 29) == 0) misTaken = 1;
         if ($urandom_range(0, 7) == 0) bFreeEn = 1;
         bFreeNum = 2'($urandom);
         cyc();
      end
      drain(16);

      @(posedge clk); #3;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
